// File: rtl/onewire_pkg.sv
// Shared 1-Wire definitions: receiver state encoding and default slot timing in 100 MHz cycles.
package onewire_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOW     = 2'd1,
      RST_LOW = 2'd2
   } ow_state_e;

   localparam int unsigned OW_MIN_LOW_CYC  = 100;
   localparam int unsigned OW_SAMPLE_CYC   = 3000;
   localparam int unsigned OW_SLOT_MAX_CYC = 12000;
   localparam int unsigned OW_RESET_CYC    = 48000;
   localparam int unsigned OW_IDLE_TO_CYC  = 50000;

endpackage

// File: rtl/one_wire_rx_if.sv
// Receiver-side bundle: bus line and enable in, decoded byte and event strobes out.
interface one_wire_rx_if;

   logic       en;
   logic       one_wire_data;
   logic [7:0] rx_byte;
   logic       valid;
   logic       busy;
   logic       reset_det;
   logic       err;

   modport master (
      input  en, one_wire_data,
      output rx_byte, valid, busy, reset_det, err
   );

   modport slave (
      output en, one_wire_data,
      input  rx_byte, valid, busy, reset_det, err
   );

endinterface

// File: rtl/onewire_sync_edge.sv
// Two-flop synchronizer for the open-drain line plus a history flop for rise/fall pulses.
module onewire_sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic line,
   output logic rise,
   output logic fall
);

   logic [2:0] sh_q, sh_d;

   always_comb begin
      sh_d = {sh_q[1:0], din};
   end

   // Reset to the idle-high level so no falling edge appears when reset releases.
   always_ff @(posedge clk) begin
      if (!rst_n) sh_q <= 3'b111;
      else        sh_q <= sh_d;
   end

   assign line = sh_q[1];
   assign rise = sh_q[1] & ~sh_q[2];
   assign fall = ~sh_q[1] & sh_q[2];

endmodule

// File: rtl/one_wire_rx.sv
// 1-Wire bit-slot receiver: times low pulses, decodes 8 LSB-first slots into a byte.
// Optional mid-byte idle timeout is built when ONEWIRE_RX_TIMEOUT_EN is defined.
module one_wire_rx
   import onewire_pkg::*;
#(
   parameter int unsigned MIN_LOW_CYC  = OW_MIN_LOW_CYC,
   parameter int unsigned SAMPLE_CYC   = OW_SAMPLE_CYC,
   parameter int unsigned SLOT_MAX_CYC = OW_SLOT_MAX_CYC,
   parameter int unsigned RESET_CYC    = OW_RESET_CYC,
   parameter int unsigned IDLE_TO_CYC  = OW_IDLE_TO_CYC
) (
   input logic           clk,
   input logic           rst_n,
   one_wire_rx_if.master bus
);

   localparam int unsigned CNT_W = $clog2(RESET_CYC + 1);
   localparam logic [CNT_W-1:0] MIN_C      = CNT_W'(MIN_LOW_CYC);
   localparam logic [CNT_W-1:0] SAMPLE_C   = CNT_W'(SAMPLE_CYC);
   localparam logic [CNT_W-1:0] SLOT_MAX_C = CNT_W'(SLOT_MAX_CYC);
   localparam logic [CNT_W-1:0] RESET_C    = CNT_W'(RESET_CYC);

   logic line, rise, fall;

   onewire_sync_edge u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (bus.one_wire_data),
      .line  (line),
      .rise  (rise),
      .fall  (fall)
   );

   ow_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       bit_cnt_q, bit_cnt_d;
   logic [7:0]       sr_q, sr_d;
   logic [7:0]       rx_byte_q, rx_byte_d;
   logic             valid_q, valid_d;
   logic             err_q, err_d;
   logic             reset_det_q, reset_det_d;
   logic [7:0]       sr_now;
   logic [3:0]       bits_now;

`ifdef ONEWIRE_RX_TIMEOUT_EN
   localparam int unsigned IDLE_W = $clog2(IDLE_TO_CYC + 1);
   localparam logic [IDLE_W-1:0] IDLE_TO_C = IDLE_W'(IDLE_TO_CYC);
   logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bit_cnt_d   = bit_cnt_q;
      sr_d        = sr_q;
      rx_byte_d   = rx_byte_q;
      valid_d     = 1'b0;
      err_d       = 1'b0;
      reset_det_d = 1'b0;
      sr_now      = sr_q;
      bits_now    = bit_cnt_q;

      case (state_q)
         IDLE: begin
            if (!bus.en) begin
               bit_cnt_d = 4'd0;
               sr_d      = 8'd0;
            end else if (fall) begin
               state_d = LOW;
               cnt_d   = '0;
            end
         end

         LOW: begin
            if (rise) begin
               state_d = IDLE;
               if (cnt_q >= MIN_C) begin
                  // A rise before the sample point commits the bit as a 1 here instead.
                  if (cnt_q < SAMPLE_C) begin
                     sr_now   = {1'b1, sr_q[7:1]};
                     bits_now = bit_cnt_q + 4'd1;
                  end
                  if (cnt_q <= SLOT_MAX_C) begin
                     sr_d      = sr_now;
                     bit_cnt_d = bits_now;
                     if (bits_now == 4'd8) begin
                        rx_byte_d = sr_now;
                        valid_d   = 1'b1;
                        bit_cnt_d = 4'd0;
                     end
                  end else begin
                     err_d     = 1'b1;
                     sr_d      = 8'd0;
                     bit_cnt_d = 4'd0;
                  end
               end
            end else begin
               if (cnt_q == SAMPLE_C - CNT_W'(1)) begin
                  sr_d      = {line, sr_q[7:1]};
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
               if (cnt_q < RESET_C) cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == RESET_C - CNT_W'(1)) state_d = RST_LOW;
            end
         end

         RST_LOW: begin
            if (rise) begin
               reset_det_d = 1'b1;
               sr_d        = 8'd0;
               bit_cnt_d   = 4'd0;
               state_d     = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase

`ifdef ONEWIRE_RX_TIMEOUT_EN
      idle_cnt_d = '0;
      if (state_q == IDLE && !fall && bit_cnt_q != 4'd0) begin
         idle_cnt_d = idle_cnt_q + IDLE_W'(1);
         if (idle_cnt_d == IDLE_TO_C) begin
            err_d      = 1'b1;
            bit_cnt_d  = 4'd0;
            sr_d       = 8'd0;
            idle_cnt_d = '0;
         end
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         bit_cnt_q   <= 4'd0;
         sr_q        <= 8'd0;
         rx_byte_q   <= 8'd0;
         valid_q     <= 1'b0;
         err_q       <= 1'b0;
         reset_det_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         sr_q        <= sr_d;
         rx_byte_q   <= rx_byte_d;
         valid_q     <= valid_d;
         err_q       <= err_d;
         reset_det_q <= reset_det_d;
      end
   end

`ifdef ONEWIRE_RX_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (!rst_n) idle_cnt_q <= '0;
      else        idle_cnt_q <= idle_cnt_d;
   end
`endif

   assign bus.rx_byte   = rx_byte_q;
   assign bus.valid     = valid_q;
   assign bus.err       = err_q;
   assign bus.reset_det = reset_det_q;
   assign bus.busy      = (bit_cnt_q != 4'd0) || (state_q != IDLE);

endmodule
